// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the iterative signed multiply/divide unit:
//   WIDTH     - operand / result width
//   CNT_BITS  - width of the iteration counter
//   ITER      - number of iterations per operation (one bit per cycle)
//   mdState_t - controller states
//   isLastIter() - true on the cycle whose counter value wraps back to zero
// -----------------------------------------------------------------------------
package multdiv_pkg;

    localparam int WIDTH    = 32;
    localparam int CNT_BITS = 5;
    localparam int ITER     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } mdState_t;

    // The counter starts at zero on the start edge, so the final iteration is
    // the one that sees ITER-1 and wraps the counter back to zero.
    function automatic logic isLastIter(input logic [CNT_BITS-1:0] cnt);
        return (cnt == CNT_BITS'(ITER - 1));
    endfunction

endpackage

// File: rtl/addsub32.sv
// -----------------------------------------------------------------------------
// addsub32
// WIDTH-bit adder/subtractor.
//   a, b  : operands
//   sub   : 0 -> sum = a + b, 1 -> sum = a - b (a + ~b + 1)
//   sum   : WIDTH-bit result
//   cout  : carry out; for subtraction 1 means "no borrow" (a >= b unsigned)
// -----------------------------------------------------------------------------
module addsub32
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] bEff_s;
    logic [WIDTH:0]   total_s;

    // Invert b and inject a carry-in of one for subtraction
    always_comb begin
        bEff_s  = sub ? ~b : b;
        total_s = {1'b0, a} + {1'b0, bEff_s} + {{WIDTH{1'b0}}, sub};
        sum     = total_s[WIDTH-1:0];
        cout    = total_s[WIDTH];
    end

endmodule

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
// Iterative signed multiplier / divider, one bit per cycle over operand
// magnitudes with a sign fix at the end.
//   clock          - single clock, rising edge
//   reset          - asynchronous, active-high
//   ctrl_MULT      - one-cycle start pulse, signed multiply (wins over DIV)
//   ctrl_DIV       - one-cycle start pulse, signed divide
//   data_operandA  - multiplicand / dividend, sampled on the start edge
//   data_operandB  - multiplier / divisor, sampled on the start edge
//   data_result    - product low word or quotient (held until next result)
//   data_exception - multiply overflow, divide overflow or divide by zero
//   data_resultRDY - one-cycle result-valid pulse
//   busy           - high from the start edge through the RDY cycle
// Latency: RDY is visible in the 33rd cycle after the start pulse
// (1 cycle for a zero divisor). Start pulses while busy are ignored.
// -----------------------------------------------------------------------------
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // Controller / datapath state
    mdState_t            state_r;
    logic [CNT_BITS-1:0] cnt_r;
    logic [WIDTH-1:0]    accHi_r;
    logic [WIDTH-1:0]    accLo_r;
    logic [WIDTH-1:0]    opMag_r;     // |multiplicand| or |divisor|
    logic                negRes_r;    // result must be negated at the end
    logic [WIDTH-1:0]    result_r;
    logic                exception_r;
    logic                rdy_r;
    logic                busy_r;

    // Combinational datapath
    logic             inIdle_s;
    logic             inDiv_s;
    logic [WIDTH-1:0] shiftHi_s;
    logic [WIDTH-1:0] stepA_s;
    logic             stepSub_s;
    logic [WIDTH-1:0] stepSum_s;
    logic             stepCout_s;
    logic [WIDTH-1:0] nextHi_s;
    logic [WIDTH-1:0] nextLo_s;
    logic [WIDTH-1:0] negLoB_s;
    logic [WIDTH-1:0] negLoSum_s;
    logic             negLoCout_s;
    logic [WIDTH-1:0] negHiA_s;
    logic [WIDTH-1:0] negHiB_s;
    logic             negHiSub_s;
    logic [WIDTH-1:0] negHiSum_s;
    logic             negHiCout_s;
    logic             signA_s;
    logic             signB_s;
    logic [WIDTH-1:0] absA_s;
    logic [WIDTH-1:0] absB_s;
    logic             divZero_s;
    logic [2*WIDTH-1:0] mulFix_s;
    logic             mulOvf_s;
    logic [WIDTH-1:0] quot_s;
    logic             divOvf_s;

    assign inIdle_s = (state_r == IDLE);
    assign inDiv_s  = (state_r == DIV);

    // Division works on the accumulator shifted left by one; the remainder in
    // accHi_r is always below the divisor (<= 2^(WIDTH-1)), so its top bit is
    // zero and nothing is lost by the shift.
    assign shiftHi_s = {accHi_r[WIDTH-2:0], accLo_r[WIDTH-1]};
    assign stepA_s   = inDiv_s ? shiftHi_s : accHi_r;
    assign stepSub_s = inDiv_s;

    // Shared add step (multiply) and trial subtract (divide)
    addsub32 #(.WIDTH(WIDTH)) uStep (
        .a    (stepA_s),
        .b    (opMag_r),
        .sub  (stepSub_s),
        .sum  (stepSum_s),
        .cout (stepCout_s)
    );

    // Next value of the 2*WIDTH accumulator for one iteration
    always_comb begin
        nextHi_s = accHi_r;
        nextLo_s = accLo_r;
        if (inDiv_s) begin
            if (stepCout_s) begin
                // No borrow: keep the difference, quotient bit is one
                {nextHi_s, nextLo_s} = {stepSum_s, accLo_r[WIDTH-2:0], 1'b1};
            end else begin
                // Borrow: restore the shifted remainder, quotient bit is zero
                {nextHi_s, nextLo_s} = {shiftHi_s, accLo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (accLo_r[0]) begin
                {nextHi_s, nextLo_s} = {stepCout_s, stepSum_s, accLo_r[WIDTH-1:1]};
            end else begin
                {nextHi_s, nextLo_s} = {1'b0, accHi_r, accLo_r[WIDTH-1:1]};
            end
        end
    end

    // The two negators serve double duty: in IDLE they form |A| and |B| from
    // the live operands; otherwise they two's-complement the final
    // accumulator (low word first, its carry feeding the high word).
    assign negLoB_s   = inIdle_s ? data_operandA : nextLo_s;
    assign negHiA_s   = inIdle_s ? {WIDTH{1'b0}} : ~nextHi_s;
    assign negHiB_s   = inIdle_s ? data_operandB : {{(WIDTH-1){1'b0}}, negLoCout_s};
    assign negHiSub_s = inIdle_s;

    addsub32 #(.WIDTH(WIDTH)) uNegLo (
        .a    ({WIDTH{1'b0}}),
        .b    (negLoB_s),
        .sub  (1'b1),
        .sum  (negLoSum_s),
        .cout (negLoCout_s)
    );

    addsub32 #(.WIDTH(WIDTH)) uNegHi (
        .a    (negHiA_s),
        .b    (negHiB_s),
        .sub  (negHiSub_s),
        .sum  (negHiSum_s),
        .cout (negHiCout_s)
    );

    // Operand magnitudes, sign-fixed results and exception conditions
    always_comb begin
        signA_s   = data_operandA[WIDTH-1];
        signB_s   = data_operandB[WIDTH-1];
        absA_s    = signA_s ? negLoSum_s : data_operandA;
        absB_s    = signB_s ? negHiSum_s : data_operandB;
        // 0 - B produces no borrow only when B is zero
        divZero_s = negHiCout_s;
        mulFix_s  = negRes_r ? {negHiSum_s, negLoSum_s} : {nextHi_s, nextLo_s};
        // Overflow unless the upper WIDTH+1 bits are all equal
        mulOvf_s  = ~((&mulFix_s[2*WIDTH-1:WIDTH-1]) | ~(|mulFix_s[2*WIDTH-1:WIDTH-1]));
        quot_s    = negRes_r ? negLoSum_s : nextLo_s;
        // A positive quotient with the top bit set only arises from MIN / -1
        divOvf_s  = ~negRes_r & nextLo_s[WIDTH-1];
    end

    // Controller, accumulator and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_BITS{1'b0}};
            accHi_r     <= {WIDTH{1'b0}};
            accLo_r     <= {WIDTH{1'b0}};
            opMag_r     <= {WIDTH{1'b0}};
            negRes_r    <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy_r <= 1'b0;
                    if (ctrl_MULT) begin
                        state_r  <= MULT;
                        busy_r   <= 1'b1;
                        cnt_r    <= {CNT_BITS{1'b0}};
                        accHi_r  <= {WIDTH{1'b0}};
                        accLo_r  <= absB_s;
                        opMag_r  <= absA_s;
                        negRes_r <= signA_s ^ signB_s;
                    end else if (ctrl_DIV) begin
                        busy_r   <= 1'b1;
                        cnt_r    <= {CNT_BITS{1'b0}};
                        accHi_r  <= {WIDTH{1'b0}};
                        negRes_r <= signA_s ^ signB_s;
                        if (divZero_s) begin
                            state_r     <= DONE;
                            accLo_r     <= {WIDTH{1'b0}};
                            opMag_r     <= {WIDTH{1'b0}};
                            result_r    <= {WIDTH{1'b0}};
                            exception_r <= 1'b1;
                            rdy_r       <= 1'b1;
                        end else begin
                            state_r <= DIV;
                            accLo_r <= absA_s;
                            opMag_r <= absB_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MULT: begin
                    cnt_r   <= cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    accHi_r <= nextHi_s;
                    accLo_r <= nextLo_s;
                    if (isLastIter(cnt_r)) begin
                        state_r     <= DONE;
                        result_r    <= mulFix_s[WIDTH-1:0];
                        exception_r <= mulOvf_s;
                        rdy_r       <= 1'b1;
                    end
                end
                DIV: begin
                    cnt_r   <= cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    accHi_r <= nextHi_s;
                    accLo_r <= nextLo_s;
                    if (isLastIter(cnt_r)) begin
                        state_r     <= DONE;
                        result_r    <= quot_s;
                        exception_r <= divOvf_s;
                        rdy_r       <= 1'b1;
                    end
                end
                DONE: begin
                    // Start pulses seen here are dropped: busy is still high
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_r;
    assign data_exception = exception_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
// Self-checking bench for multdiv_unit. Expected results come from a plain
// 64-bit arithmetic reference model. Inputs are driven and outputs sampled on
// the falling clock edge. Cycle numbering: the start pulse is high in cycle 0;
// the value seen at the k-th falling edge after that is cycle k.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total;
    int bad;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: signed 64-bit arithmetic
    function automatic void model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output bit exc, output int lat);
        longint sa;
        longint sb;
        longint p;
        longint q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (isMul) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p != longint'(signed'(p[31:0])));
            lat = 33;
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            res = q[31:0];
            exc = (q > 64'sd2147483647);
            lat = 33;
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] sp [5];
        int sel;
        sp[0] = 32'h8000_0000;
        sp[1] = 32'hFFFF_FFFF;
        sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'h0000_0001;
        sp[4] = 32'h0000_0000;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 2000)) - 32'd1000;
            2:       return sp[$urandom_range(0, 4)];
            default: return 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
        endcase
    endfunction

    // Issue one start pulse and wait (bounded) for RDY; lat=-1 on timeout
    task automatic do_op(input bit dropReset, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic exc);
        @(negedge clock);
        if (dropReset) reset = 1'b0;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        lat = -1;
        res = 32'd0;
        exc = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (data_resultRDY === 1'b1) begin
                lat = k;
                res = data_result;
                exc = data_exception;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        repeat (3) @(negedge clock);
        total++; if (data_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=%h", data_result, 32'd0); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exception got=%b want=0", data_exception); end
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", data_resultRDY); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_mult_basic();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        model(1'b1, 32'd7, -32'sd6, expRes, expExc, expLat);
        do_op(1'b0, 1'b1, 1'b0, 32'd7, -32'sd6, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL mult_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL mult_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL mult_exc got=%b want=%b", exc, expExc); end
        @(negedge clock);
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL rdy_one_cycle got=%b want=0", data_resultRDY); end
        total++; if (data_result !== expRes) begin bad++; $display("FAIL result_hold got=%h want=%h", data_result, expRes); end
    endtask

    task automatic test_div_basic();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        model(1'b0, -32'sd100, 32'd7, expRes, expExc, expLat);
        do_op(1'b0, 1'b0, 1'b1, -32'sd100, 32'd7, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL div_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL div_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL div_exc got=%b want=%b", exc, expExc); end
    endtask

    task automatic test_div_zero();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        model(1'b0, 32'd1234, 32'd0, expRes, expExc, expLat);
        do_op(1'b0, 1'b0, 1'b1, 32'd1234, 32'd0, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL divzero_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL divzero_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL divzero_exc got=%b want=%b", exc, expExc); end
        model(1'b1, 32'h0001_0000, 32'h0001_0000, expRes, expExc, expLat);
        do_op(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL multovf_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL multovf_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL multovf_exc got=%b want=%b", exc, expExc); end
    endtask

    task automatic test_div_overflow();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, expRes, expExc, expLat);
        do_op(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL divovf_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL divovf_result got=%h want=%h", res, 32'h8000_0000); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL divovf_exc got=%b want=%b", exc, expExc); end
    endtask

    task automatic test_both_start();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        model(1'b1, 32'd6, 32'd3, expRes, expExc, expLat);
        do_op(1'b0, 1'b1, 1'b1, 32'd6, 32'd3, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL both_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL both_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL both_exc got=%b want=%b", exc, expExc); end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] a, b, expRes, gotRes; bit expExc; int expLat;
        int rdyCount, rdyCycle; logic busy33, busy34;
        a = pick_operand();
        b = pick_operand();
        model(1'b1, a, b, expRes, expExc, expLat);
        rdyCount = 0; rdyCycle = -1; gotRes = 32'd0; busy33 = 1'b0; busy34 = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = a; data_operandB = b;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            if (data_resultRDY === 1'b1) begin
                rdyCount++;
                rdyCycle = c;
                gotRes = data_result;
            end
            if (c == 33) busy33 = busy;
            if (c == 34) busy34 = busy;
            ctrl_DIV = (c == 5 || c == 33);
            if (c == 5) begin
                // Fresh operands, including a zero divisor, must not be latched
                data_operandA = $urandom;
                data_operandB = 32'd0;
            end
        end
        ctrl_DIV = 1'b0;
        total++; if (rdyCount !== 1) begin bad++; $display("FAIL ignore_rdycount got=%0d want=1", rdyCount); end
        total++; if (rdyCycle !== 33) begin bad++; $display("FAIL ignore_rdycycle got=%0d want=33", rdyCycle); end
        total++; if (gotRes !== expRes) begin bad++; $display("FAIL ignore_result got=%h want=%h", gotRes, expRes); end
        total++; if (busy33 !== 1'b1) begin bad++; $display("FAIL ignore_busy33 got=%b want=1", busy33); end
        total++; if (busy34 !== 1'b0) begin bad++; $display("FAIL ignore_busy34 got=%b want=0", busy34); end
    endtask

    task automatic test_reset_mid();
        int lat, expLat; logic [31:0] res, expRes; logic exc; bit expExc;
        int sawRdy; logic busy10;
        sawRdy = 0;
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = $urandom; data_operandB = $urandom | 32'd1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (data_resultRDY === 1'b1) sawRdy++;
        end
        busy10 = busy;
        total++; if (busy10 !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b want=1", busy10); end
        #2 reset = 1'b1;
        #1;
        total++; if (data_result !== 32'd0) begin bad++; $display("FAIL midreset_result got=%h want=%h", data_result, 32'd0); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL midreset_exc got=%b want=0", data_exception); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        repeat (3) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) sawRdy++;
        end
        total++; if (sawRdy !== 0) begin bad++; $display("FAIL midreset_rdy got=%0d want=0", sawRdy); end
        model(1'b1, 32'd3, 32'd3, expRes, expExc, expLat);
        do_op(1'b1, 1'b1, 1'b0, 32'd3, 32'd3, lat, res, exc);
        total++; if (lat !== expLat) begin bad++; $display("FAIL afterreset_lat got=%0d want=%0d", lat, expLat); end
        total++; if (res !== expRes) begin bad++; $display("FAIL afterreset_result got=%h want=%h", res, expRes); end
        total++; if (exc !== expExc) begin bad++; $display("FAIL afterreset_exc got=%b want=%b", exc, expExc); end
    endtask

    task automatic test_random();
        int lat, expLat; logic [31:0] a, b, res, expRes; logic exc; bit expExc, isMul;
        for (int i = 0; i < 30; i++) begin
            isMul = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            model(isMul, a, b, expRes, expExc, expLat);
            do_op(1'b0, isMul, ~isMul, a, b, lat, res, exc);
            total++; if (lat !== expLat) begin bad++; $display("FAIL rand_lat op=%0d a=%h b=%h got=%0d want=%0d", isMul, a, b, lat, expLat); end
            total++; if (res !== expRes) begin bad++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h want=%h", isMul, a, b, res, expRes); end
            total++; if (exc !== expExc) begin bad++; $display("FAIL rand_exc op=%0d a=%h b=%h got=%b want=%b", isMul, a, b, exc, expExc); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_zero();
        test_div_overflow();
        test_both_start();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
